// File: rtl/qea_host_seq.sv
// qea_host_seq: hardware job sequencer for QEA ctx/state load, start and readout.
// Define QEA_HOST_CYCLE_CNT_EN to add the o_exec_cycles execution counter.
module qea_host_seq #(
    parameter int PE_NUM                  = 4,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int RD_LATENCY              = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_go,
    input  logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH:0]   i_ins_num,
    input  logic                               i_ctx_valid,
    output logic                               o_ctx_ready,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0] i_ctx_data,
    output logic                               o_res_valid,
    input  logic                               i_res_ready,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0] o_res_data,
    output logic                               o_res_last,
    output logic                               o_busy,
    output logic                               o_err,
    output logic                               o_qea_start,
    output logic [MAX_QBIT_WIDTH-1:0]          o_qea_qbit_num,
    output logic                               o_qea_ctx_en,
    output logic                               o_qea_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0] o_qea_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0] o_qea_ctx_data,
    output logic                               o_qea_state_ena,
    output logic                               o_qea_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]        o_qea_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0] o_qea_state_dina,
    input  logic                               i_qea_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0] i_qea_state_dout
`ifdef QEA_HOST_CYCLE_CNT_EN
    ,
    output logic [31:0]                        o_exec_cycles
`endif
);

    localparam int SW = PE_NUM * STATE_DATA_WIDTH;
    localparam int CW = STATE_ADDR_WIDTH + 1;
    localparam int IW = GATE_CONTEXT_ADDR_WIDTH + 1;

    // |0...0> amplitude 1.0 in Q2.30 on the real half
    localparam logic [STATE_DATA_WIDTH-1:0] AMP_ONE =
        {2'b01, {(STATE_DATA_WIDTH-2){1'b0}}};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CTX   = 3'd1;
    localparam logic [2:0] S_ST    = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_START = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd5;
    localparam logic [2:0] S_RD    = 3'd6;

    logic [2:0]            state;
    logic [IW-1:0]         ins_num;
    logic [IW-1:0]         ctx_cnt;
    logic [CW-1:0]         n_words;
    logic [CW-1:0]         st_cnt;
    logic [CW-1:0]         rd_cnt;
    logic [RD_LATENCY-1:0] rd_pipe;
    logic                  go_ok;
    logic                  go_acc;
    logic                  ctx_acc;
    logic                  rd_issue;
    logic                  res_hs;

    assign go_ok = (i_qbit_num >= MAX_QBIT_WIDTH'(2)) &&
                   ((int'(i_qbit_num) - 2) <= STATE_ADDR_WIDTH);
    assign go_acc  = (state == S_IDLE) && i_go && go_ok;
    assign ctx_acc = (state == S_CTX) && i_ctx_valid;
    assign res_hs  = o_res_valid && i_res_ready;

    // one read in flight: issue only when the pipe and output reg are empty
    assign rd_issue = (state == S_RD) && (rd_pipe == '0) &&
                      !o_res_valid && (rd_cnt < n_words);

    assign o_ctx_ready     = (state == S_CTX);
    assign o_busy          = (state != S_IDLE);
    assign o_qea_start     = (state == S_START);
    assign o_qea_state_wea = (state == S_ST);
    assign o_qea_state_ena = (state == S_ST) || rd_issue;

    always_comb begin
        o_qea_state_addra = '0;
        o_qea_state_dina  = '0;
        if (state == S_ST) begin
            o_qea_state_addra = st_cnt[STATE_ADDR_WIDTH-1:0];
            if (st_cnt == '0)
                o_qea_state_dina[SW-1 -: STATE_DATA_WIDTH] = AMP_ONE;
        end else if (state == S_RD) begin
            o_qea_state_addra = rd_cnt[STATE_ADDR_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            ins_num        <= '0;
            ctx_cnt        <= '0;
            n_words        <= '0;
            st_cnt         <= '0;
            rd_cnt         <= '0;
            rd_pipe        <= '0;
            o_err          <= 1'b0;
            o_res_valid    <= 1'b0;
            o_res_last     <= 1'b0;
            o_res_data     <= '0;
            o_qea_qbit_num <= '0;
            o_qea_ctx_en   <= 1'b0;
            o_qea_ctx_wea  <= 1'b0;
            o_qea_ctx_addr <= '0;
            o_qea_ctx_data <= '0;
        end else begin
            o_err         <= 1'b0;
            o_qea_ctx_en  <= ctx_acc;
            o_qea_ctx_wea <= ctx_acc;
            if (ctx_acc) begin
                o_qea_ctx_addr <= ctx_cnt[GATE_CONTEXT_ADDR_WIDTH-1:0];
                o_qea_ctx_data <= i_ctx_data;
            end
            rd_pipe <= (rd_pipe << 1) | RD_LATENCY'(rd_issue);
            unique case (state)
                S_IDLE: begin
                    if (go_acc) begin
                        o_qea_qbit_num <= i_qbit_num;
                        ins_num <= i_ins_num;
                        n_words <= CW'(1) << (i_qbit_num - MAX_QBIT_WIDTH'(2));
                        ctx_cnt <= '0;
                        st_cnt  <= '0;
                        rd_cnt  <= '0;
                        state   <= (i_ins_num != '0) ? S_CTX : S_ST;
                    end else if (i_go) begin
                        o_err <= 1'b1;
                    end
                end
                S_CTX: begin
                    if (ctx_acc) begin
                        ctx_cnt <= ctx_cnt + 1'b1;
                        if (ctx_cnt + 1'b1 == ins_num)
                            state <= S_ST;
                    end
                end
                S_ST: begin
                    if (st_cnt == n_words - CW'(1)) begin
                        st_cnt <= '0;
                        state  <= S_GAP;
                    end else begin
                        st_cnt <= st_cnt + 1'b1;
                    end
                end
                S_GAP:   state <= S_START;
                S_START: state <= S_WAIT;
                S_WAIT: begin
                    if (i_qea_complete)
                        state <= S_RD;
                end
                S_RD: begin
                    if (rd_issue)
                        rd_cnt <= rd_cnt + 1'b1;
                    if (rd_pipe[RD_LATENCY-1]) begin
                        o_res_valid <= 1'b1;
                        o_res_data  <= i_qea_state_dout;
                        o_res_last  <= (rd_cnt == n_words);
                    end else if (res_hs) begin
                        o_res_valid <= 1'b0;
                        o_res_last  <= 1'b0;
                        if (o_res_last)
                            state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef QEA_HOST_CYCLE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            o_exec_cycles <= '0;
        else if (go_acc)
            o_exec_cycles <= '0;
        else if ((o_qea_start || (state == S_WAIT && !i_qea_complete)) &&
                 (o_exec_cycles != '1))
            o_exec_cycles <= o_exec_cycles + 32'd1;
    end
`endif

endmodule

// File: doc/qea_host_seq.md
Name: qea_host_seq

Overview:
- Host-side initiator for the QEA accelerator: drives its context-load, state-load, start and readout ports in hardware, replacing bench-driven sequencing.
- Per job: streams gate-context words from an upstream valid/ready source into ctx RAM, writes the |0…0> initial state, pulses start, waits for QEA completion, then streams back every state word over a valid/ready result port.
- Sits between a host DMA/AXI-stream shim and the QEA instance.

Parameters:
- PE_NUM, 4, PE lanes per state word.
- STATE_DATA_WIDTH, 64, one complex amplitude {re[63:32], im[31:0]}, Q2.30.
- STATE_ADDR_WIDTH, 16, QEA state RAM address width.
- GATE_CONTEXT_DATA_WIDTH, 64, ctx word width.
- GATE_CONTEXT_ADDR_WIDTH, 16, ctx RAM address width.
- MAX_QBIT_WIDTH, 6, width of the qubit count.
- RD_LATENCY, 1, cycles from state read address to valid i_qea_state_dout (1..4).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_go  in  1  job start pulse; sampled only in IDLE.
- i_qbit_num  in  MAX_QBIT_WIDTH  qubit count; latched on i_go.
- i_ins_num  in  GATE_CONTEXT_ADDR_WIDTH+1  ctx words to load; latched on i_go.
- i_ctx_valid / o_ctx_ready  in/out  1  ctx stream handshake.
- i_ctx_data  in  GATE_CONTEXT_DATA_WIDTH  ctx word.
- o_res_valid / i_res_ready  out/in  1  result stream handshake.
- o_res_data  out  PE_NUM*STATE_DATA_WIDTH  state word read back.
- o_res_last  out  1  high with the final result word.
- o_busy  out  1  high in any non-IDLE state.
- o_err  out  1  one-cycle pulse on a rejected i_go.
- o_qea_start  out  1  one-cycle start pulse to QEA.
- o_qea_qbit_num  out  MAX_QBIT_WIDTH  latched qubit count.
- o_qea_ctx_en, o_qea_ctx_wea  out  1  ctx write strobe.
- o_qea_ctx_addr  out  GATE_CONTEXT_ADDR_WIDTH.
- o_qea_ctx_data  out  GATE_CONTEXT_DATA_WIDTH.
- o_qea_state_ena, o_qea_state_wea  out  1  state RAM enable / write.
- o_qea_state_addra  out  STATE_ADDR_WIDTH.
- o_qea_state_dina  out  PE_NUM*STATE_DATA_WIDTH.
- i_qea_complete  in  1  QEA completion level.
- i_qea_state_dout  in  PE_NUM*STATE_DATA_WIDTH  QEA read data.

Behaviour:
- Reset: every output 0, FSM to IDLE, counters cleared. Reset mid-job aborts immediately; o_qea_start is never issued after rst.
- Word count N = 2^(q-2). i_go is rejected (o_err pulse, stay IDLE) if q<2 or q-2>STATE_ADDR_WIDTH. i_go while busy is ignored with no o_err.
- States and transitions:
  - IDLE: on a valid i_go, go to CTX if ins_num>0, else ST.
  - CTX: o_ctx_ready=1; each accepted beat issues a registered write next cycle (en=wea=1, addr 0,1,2…). After ins_num beats, go to ST. Stalls with valid low insert no writes.
  - ST: N consecutive write cycles, addr 0..N-1, ena=wea=1. Addr 0 data is PE lane PE_NUM-1 (MSBs) = 64'h40000000_00000000, all other bits 0. Every other addr writes all zeros.
  - GAP: one idle cycle, then START.
  - START: o_qea_start=1 for exactly one cycle, then WAIT.
  - WAIT: on i_qea_complete=1, go to RD.
  - RD: read with ena=1, wea=0, addr k; capture data after RD_LATENCY cycles into an output register; hold o_res_valid until i_res_ready. The next read issues in the cycle after the handshake, so only one read is outstanding.
  - After the word at addr N-1 handshakes with o_res_last=1, go to IDLE. The next i_go is accepted the following cycle.
- Result data is held stable while valid && !ready.
- Address counters are STATE_ADDR_WIDTH+1 bits wide; no wrap-around when N=2^STATE_ADDR_WIDTH.

Optional Feature:
- QEA_HOST_CYCLE_CNT_EN: adds output o_exec_cycles (32 bits), which counts cycles from the o_qea_start cycle (inclusive) to the first WAIT cycle with i_qea_complete=1 (exclusive). The counter saturates at 2^32-1, holds until the next accepted i_go, and resets to 0 on rst.
- Without the macro: no port, no counter.

Test Plan:
- q=4, ins_num=3, ctx beats A,B,C with valid every cycle -> ctx writes addr 0,1,2 in 3 consecutive cycles; state writes addr 0..3 with addr 0 = 64'h40000000_00000000 in the top lane; one o_qea_start pulse.
- Ctx valid toggling 1,0,1,0 -> exactly ins_num writes at contiguous addresses, none during gaps.
- Model asserts i_qea_complete 20 cycles after start, i_res_ready=1 -> 4 result words matching model data for addr 0..3, o_res_last on the 4th; with the macro, o_exec_cycles=20.
- i_res_ready low for 5 cycles on word 1 -> o_res_data stable, no new read issued, no word lost or duplicated.
- i_go with q=1, and with q=19 when STATE_ADDR_WIDTH=16 -> o_err pulse, o_busy stays 0, no QEA strobes.
- rst asserted in WAIT -> next cycle all outputs 0, IDLE; a subsequent i_go runs a full job correctly.
